// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the serial-load SRAM word controller.
// Optional feature macro: SRAM_PARITY_EN (stores an even-parity bit per word).
package sram_ctrl_pkg;

    // Access FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    // Widest word the parity helper accepts; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int PARITY_MAX_WIDTH = 64;

    // Even parity bit: makes the total number of ones (data + parity) even.
    function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Behavioural word storage: synchronous write, combinational read, single address.
module sram_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Commit a word on the write strobe.
    // NOTE: the array is deliberately left without a reset; contents are undefined
    // until written, and resetting a RAM would stop it mapping onto a real macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sram_serial_ctrl.sv
// Serial-load SRAM word controller: an LSB-first shift register gathers a word,
// then a multi-cycle access FSM writes it to, or reads a word from, the array.
// Optional feature macro: SRAM_PARITY_EN (parity bit per word, parity_err output).
module sram_serial_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  serial_in,
    input  logic                  shift,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  word_full,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
`ifdef SRAM_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  req_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int ACC_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
`ifdef SRAM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    state_t                state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_shifted;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic                  last_cycle;
    logic                  mem_we;
    logic                  rd_load;
    logic                  err_d;
    logic [MEM_W-1:0]      mem_wdata;
    logic [MEM_W-1:0]      mem_rdata;

    assign busy       = (state_q != ST_IDLE);
    assign word_full  = (bit_cnt_q == CNT_W'(DATA_WIDTH));
    assign last_cycle = (acc_q == ACC_W'(ACCESS_CYCLES - 1));

    // New bit enters at the MSB so the first bit shifted ends up in bit 0.
    generate
        if (DATA_WIDTH == 1) begin : g_sreg_one
            assign sreg_shifted = serial_in;
        end else begin : g_sreg_many
            assign sreg_shifted = {serial_in, sreg_q[DATA_WIDTH-1:1]};
        end
    endgenerate

    // Array write data, with the parity bit prepended when enabled.
`ifdef SRAM_PARITY_EN
    logic [PARITY_MAX_WIDTH-1:0] par_wr_in;
    logic [PARITY_MAX_WIDTH-1:0] par_rd_in;

    // Zero-extend words to the parity helper's fixed width.
    always_comb begin
        par_wr_in                 = '0;
        par_rd_in                 = '0;
        par_wr_in[DATA_WIDTH-1:0] = sreg_q;
        par_rd_in[DATA_WIDTH-1:0] = mem_rdata[DATA_WIDTH-1:0];
    end

    assign mem_wdata = {even_parity(par_wr_in), sreg_q};
`else
    assign mem_wdata = sreg_q;
`endif

    sram_array #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // FSM state, access counter and latched address.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state decode: accept or reject requests in IDLE, time out accesses.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; an unassigned path in always_comb would infer a latch.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        mem_we  = 1'b0;
        rd_load = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                acc_d = '0;
                if (w_en && !r_en && word_full) begin
                    state_d = ST_WRITE;
                    addr_d  = addr;
                end else if (r_en && !w_en) begin
                    state_d = ST_READ;
                    addr_d  = addr;
                end else if (w_en) begin
                    // Both requests together, or a write of an incomplete word.
                    err_d = 1'b1;
                end
            end
            ST_WRITE, ST_READ: begin
                if (last_cycle) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    mem_we  = (state_q == ST_WRITE);
                    rd_load = (state_q == ST_READ);
                end else begin
                    acc_d = acc_q + ACC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shift register and saturating bit count; frozen while an access runs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sreg_q    <= '0;
            bit_cnt_q <= '0;
        end else if (mem_we) begin
            bit_cnt_q <= '0;
        end else if (shift && !busy) begin
            sreg_q <= sreg_shifted;
            if (!word_full) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
        end
    end

    // Registered read data and one-cycle status pulses.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            req_err    <= 1'b0;
        end else begin
            data_valid <= rd_load;
            req_err    <= err_d;
            if (rd_load) begin
                data_out <= mem_rdata[DATA_WIDTH-1:0];
            end
        end
    end

`ifdef SRAM_PARITY_EN
    // Flag a stored-parity mismatch alongside the data_valid pulse.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= rd_load && (even_parity(par_rd_in) != mem_rdata[DATA_WIDTH]);
        end
    end
`endif

endmodule

// File: tb/tb_sram_serial_ctrl.sv
// Testbench for sram_serial_ctrl: directed scenarios plus randomized traffic,
// reads checked by a scoreboard monitor against a word-level memory model.
`timescale 1ns/1ps
module tb_sram_serial_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int AC    = 2;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          serial_in = 1'b0;
    logic          shift = 1'b0;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          word_full;
    logic          busy;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          req_err;
`ifdef SRAM_PARITY_EN
    logic          parity_err;
`endif

    always #5 clk = ~clk;

    sram_serial_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .ACCESS_CYCLES (AC)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .serial_in  (serial_in),
        .shift      (shift),
        .w_en       (w_en),
        .r_en       (r_en),
        .addr       (addr),
        .word_full  (word_full),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
`ifdef SRAM_PARITY_EN
        .parity_err (parity_err),
`endif
        .req_err    (req_err)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_written [DEPTH];
    bit            m_bits [$];   // most recent DW bits shifted, oldest first
    int            m_cnt;        // bits shifted since last write/reset, saturating

    function automatic void m_reset();
        m_bits.delete();
        for (int i = 0; i < DW; i++) m_bits.push_back(1'b0);
        m_cnt = 0;
    endfunction

    function automatic logic [DW-1:0] m_word();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < DW; i++) w[i] = m_bits[m_bits.size() - DW + i];
        return w;
    endfunction

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q [$];
    bit            exp_par_q [$];
    int            rd_exp = 0, dv_seen = 0;
    int            err_exp = 0, err_seen = 0;

    // Monitor: every data_valid pops one expected read; req_err pulses are counted.
    always @(negedge clk) begin
        if (arst_n) begin
            if (data_valid) begin
                dv_seen++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_data_valid: data_out 0x%0h with no read pending (t=%0t)",
                             data_out, $time);
                end else begin
                    check("read_data", data_out, exp_q.pop_front());
`ifdef SRAM_PARITY_EN
                    check("parity_err", parity_err, exp_par_q.pop_front());
`else
                    void'(exp_par_q.pop_front());
`endif
                end
            end
`ifdef SRAM_PARITY_EN
            else if (parity_err) begin
                check("parity_err_without_valid", parity_err, 0);
            end
`endif
            if (req_err) err_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input bit b);
        shift = 1'b1;
        serial_in = b;
        step();
        shift = 1'b0;
        m_bits.push_back(b);
        if (m_bits.size() > DW) void'(m_bits.pop_front());
        if (m_cnt < DW) m_cnt++;
    endtask

    task automatic shift_word(input logic [DW-1:0] w);
        for (int i = 0; i < DW; i++) shift_bit(w[i]);
        check("word_full_after_shift", word_full, 1);
    endtask

    // Called just after the request edge: busy for AC cycles, then idle.
    task automatic wait_access(input string name);
        for (int i = 0; i < AC; i++) begin
            check({name, "_busy"}, busy, 1);
            step();
        end
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic do_write(input logic [AW-1:0] a);
        bit ok;
        ok = (m_cnt == DW);
        w_en = 1'b1;
        addr = a;
        step();
        w_en = 1'b0;
        addr = AW'($urandom);   // must not disturb the latched address
        if (ok) begin
            wait_access("write");
            m_mem[a]     = m_word();
            m_written[a] = 1'b1;
            m_cnt        = 0;
            check("write_clears_word_full", word_full, 0);
        end else begin
            err_exp++;
            check("partial_write_req_err", req_err, 1);
            check("partial_write_not_busy", busy, 0);
            step();
            check("req_err_one_cycle", req_err, 0);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input bit par_exp);
        exp_q.push_back(m_mem[a]);
        exp_par_q.push_back(par_exp);
        rd_exp++;
        r_en = 1'b1;
        addr = a;
        step();
        r_en = 1'b0;
        addr = AW'($urandom);
        wait_access("read");
        check("read_data_valid", data_valid, 1);
    endtask

    task automatic do_conflict(input logic [AW-1:0] a);
        w_en = 1'b1;
        r_en = 1'b1;
        addr = a;
        step();
        w_en = 1'b0;
        r_en = 1'b0;
        err_exp++;
        check("conflict_req_err", req_err, 1);
        check("conflict_not_busy", busy, 0);
        step();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_word_full"}, word_full, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_data_out"}, data_out, 0);
        check({name, "_data_valid"}, data_valid, 0);
        check({name, "_req_err"}, req_err, 0);
    endtask

    task automatic pulse_reset_mid_cycle(input string name);
        #2;
        arst_n = 1'b0;
        #1;
        check_all_zero(name);
        m_reset();
        @(negedge clk);
        arst_n = 1'b1;
        step();
        check({name, "_released_word_full"}, word_full, 0);
    endtask

    // Hard stop if the run ever stalls.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] held_word;
    logic [DW-1:0] rnd_word;
    logic [AW-1:0] ra;

    initial begin
        m_reset();
        for (int i = 0; i < DEPTH; i++) m_written[i] = 1'b0;

        // 1: reset values, then mid-cycle async reset with a full word loaded
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        arst_n = 1'b1;
        step();
        shift_word(8'h5A);
        pulse_reset_mid_cycle("mid_reset");

        // 2: write 0xA5 to 3 and read it back
        shift_word(8'hA5);
        do_write(4'd3);
        do_read(4'd3, 1'b0);

        // 3: boundary addresses
        shift_word(8'h3C);
        do_write(4'd0);
        shift_word(8'hC3);
        do_write(4'd15);
        do_read(4'd0, 1'b0);
        do_read(4'd15, 1'b0);
        do_read(4'd3, 1'b0);

        // 4: write with an incomplete word, and simultaneous requests
        for (int i = 0; i < 5; i++) shift_bit(1'($urandom));
        check("partial_word_full", word_full, 0);
        do_write(4'd3);
        do_read(4'd3, 1'b0);
        do_conflict(4'd3);

        // 5: requests and shifts held through a read are ignored
        for (int i = 0; i < 3; i++) shift_bit(1'($urandom));
        held_word = m_word();
        exp_q.push_back(m_mem[4'd3]);
        exp_par_q.push_back(1'b0);
        rd_exp++;
        r_en = 1'b1;
        addr = 4'd3;
        step();
        w_en = 1'b1;
        shift = 1'b1;
        serial_in = ~held_word[0];
        for (int i = 0; i < AC; i++) begin
            check("held_busy", busy, 1);
            step();
        end
        r_en = 1'b0;
        w_en = 1'b0;
        shift = 1'b0;
        check("held_idle", busy, 0);
        check("held_word_full_kept", word_full, 1);
        step();
        do_write(4'd7);
        do_read(4'd7, 1'b0);
        check("held_model_word", m_mem[4'd7], held_word);

        // 6: reset during the first write cycle aborts the write
        shift_word(~m_mem[4'd3]);
        w_en = 1'b1;
        addr = 4'd3;
        step();
        w_en = 1'b0;
        pulse_reset_mid_cycle("abort_reset");
        do_read(4'd3, 1'b0);

`ifdef SRAM_PARITY_EN
        shift_word(8'h96);
        do_write(4'd5);
        dut.u_array.mem[5][DW] = ~dut.u_array.mem[5][DW];
        do_read(4'd5, 1'b1);
`endif

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            ra = AW'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    rnd_word = DW'($urandom);
                    shift_word(rnd_word);
                    do_write(ra);
                end
                1: begin
                    if (!m_written[ra]) begin
                        shift_word(DW'($urandom));
                        do_write(ra);
                    end
                    do_read(ra, 1'b0);
                end
                2: begin
                    for (int i = 0; i < int'($urandom_range(0, DW + 2)); i++) shift_bit(1'($urandom));
                    do_write(ra);
                end
                default: begin
                    do_conflict(ra);
                end
            endcase
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (4) step();
        check("data_valid_count", dv_seen, rd_exp);
        check("req_err_count", err_seen, err_exp);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
